// File: rtl/p12_pkg.sv
// Shared types and constants for the p12 configuration loader.
// Latch-select codes match the order in which the planes are strobed.
package p12_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_STROBE = 2'd2
    } state_e;

    localparam logic [1:0] CFG_V  = 2'd1;
    localparam logic [1:0] CFG_H  = 2'd2;
    localparam logic [1:0] CFG_D  = 2'd3;
    localparam int         PLANES = 4;

    // Plane p is followed by the strobe of latch set p+1 (v, h, d).
    function automatic logic [1:0] plane_code(input logic [1:0] plane);
        return plane + 2'd1;
    endfunction

endpackage

// File: rtl/p12_byte_serializer.sv
// Byte-to-bit serializer feeding the grid scan chain, LSB first.
// in_ready rises on the last held bit so bytes stream back-to-back.
module p12_byte_serializer #(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift_en,
    input  logic       fetch_en,
    input  logic       plane_done,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sc_bit,
    output logic       shift
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int FW     = $clog2(NBYTES + 1);

    logic [7:0]    byte_r;
    logic [3:0]    bit_cnt_r;
    logic [FW-1:0] fetched_r;
    logic          accept_s;

    assign shift    = shift_en && (bit_cnt_r != 4'd0);
    assign in_ready = fetch_en && (bit_cnt_r <= 4'd1) && (fetched_r < FW'(NBYTES));
    assign accept_s = in_valid && in_ready;
    assign sc_bit   = byte_r[0];

    // Byte register, remaining-bit count and per-plane fetch count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_r    <= 8'd0;
            bit_cnt_r <= 4'd0;
            fetched_r <= '0;
        end else begin
            if (accept_s) begin
                byte_r    <= in_data;
                bit_cnt_r <= 4'd8;
            end else if (shift) begin
                byte_r    <= {1'b0, byte_r[7:1]};
                bit_cnt_r <= bit_cnt_r - 4'd1;
            end else begin
                byte_r    <= byte_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if (plane_done) begin
                fetched_r <= '0;
            end else if (accept_s) begin
                fetched_r <= fetched_r + FW'(1);
            end else begin
                fetched_r <= fetched_r;
            end
        end
    end

endmodule

// File: rtl/p12_cfg_loader.sv
// Loads four scan planes into the p12 grid, strobing the v/h/d latches after
// the first three, and returns the pre-load flip-flop state as bytes.
module p12_cfg_loader
    import p12_pkg::*;
#(
    parameter int CHAIN_LEN     = 64,
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       configured,
    input  logic       run_lb,
    input  logic [1:0] run_lbc,
    output logic       g_se,
    output logic       g_sc,
    output logic [1:0] g_cfg_lbc,
    output logic       g_lb,
    output logic       g_ff_gate,
    output logic       g_l_gate,
    input  logic       g_sc_ret
);

    localparam int CW = $clog2(CHAIN_LEN);
    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    state_e        state_r;
    logic [1:0]    plane_r;
    logic [CW-1:0] cyc_r;
    logic [SW-1:0] strobe_cnt_r;
    logic          configured_r;
    logic          run_lb_r;
    logic [7:0]    col_r;
    logic [2:0]    col_cnt_r;
    logic [7:0]    rd_data_r;
    logic          rd_valid_r;

    logic shift_s;
    logic sc_bit_s;
    logic shift_en_s;
    logic fetch_en_s;
    logic plane_done_s;
    logic strobe_last_s;

    assign shift_en_s    = (state_r == ST_SHIFT);
    assign strobe_last_s = (state_r == ST_STROBE) && (strobe_cnt_r == SW'(STROBE_CYCLES - 1));
    // Prefetching in the last strobe cycle lets the next plane shift immediately.
    assign fetch_en_s    = shift_en_s || strobe_last_s;
    assign plane_done_s  = shift_s && (cyc_r == CW'(CHAIN_LEN - 1));

    p12_byte_serializer #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en_s),
        .fetch_en   (fetch_en_s),
        .plane_done (plane_done_s),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sc_bit     (sc_bit_s),
        .shift      (shift_s)
    );

    // Sequencer FSM with plane, shift-cycle and strobe counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            plane_r      <= 2'd0;
            cyc_r        <= '0;
            strobe_cnt_r <= '0;
            configured_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_SHIFT;
                        plane_r <= 2'd0;
                        cyc_r   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (plane_done_s) begin
                        cyc_r <= '0;
                        if (plane_r == 2'(PLANES - 1)) begin
                            state_r      <= ST_IDLE;
                            configured_r <= 1'b1;
                        end else begin
                            state_r      <= ST_STROBE;
                            strobe_cnt_r <= '0;
                        end
                    end else if (shift_s) begin
                        cyc_r <= cyc_r + CW'(1);
                    end
                end
                ST_STROBE: begin
                    if (strobe_last_s) begin
                        state_r <= ST_SHIFT;
                        plane_r <= plane_r + 2'd1;
                    end else begin
                        strobe_cnt_r <= strobe_cnt_r + SW'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Readback collector: chain-out bits of plane 0, packed LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r      <= 8'd0;
            col_cnt_r  <= 3'd0;
            rd_data_r  <= 8'd0;
            rd_valid_r <= 1'b0;
            run_lb_r   <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            run_lb_r   <= run_lb;
            if (shift_s && (plane_r == 2'd0)) begin
                col_r     <= {g_sc_ret, col_r[7:1]};
                col_cnt_r <= col_cnt_r + 3'd1;
                if (col_cnt_r == 3'd7) begin
                    rd_data_r  <= {g_sc_ret, col_r[7:1]};
                    rd_valid_r <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign configured = configured_r;
    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;

    // Grid control decode from the registered state.
    always_comb begin
        g_se      = 1'b0;
        g_sc      = 1'b0;
        g_cfg_lbc = run_lbc;
        g_lb      = 1'b0;
        g_ff_gate = 1'b0;
        g_l_gate  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                g_lb      = run_lb_r;
                g_ff_gate = configured_r;
                g_l_gate  = configured_r;
            end
            ST_SHIFT: begin
                g_se      = 1'b1;
                g_cfg_lbc = 2'd0;
                g_ff_gate = shift_s;
                if (shift_s) begin
                    g_sc = sc_bit_s;
                end else begin
                    g_sc = 1'b0;
                end
            end
            ST_STROBE: begin
                g_se      = 1'b1;
                g_cfg_lbc = plane_code(plane_r);
            end
            default: begin
                g_se = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_p12_cfg_loader.sv
// Scoreboard bench for p12_cfg_loader with a behavioural 64-bit grid chain.
module tb_p12_cfg_loader;

    localparam int N  = 64;
    localparam int NB = N / 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       configured;
    logic       run_lb = 1'b0;
    logic [1:0] run_lbc = 2'd0;
    logic       g_se, g_sc, g_lb, g_ff_gate, g_l_gate, g_sc_ret;
    logic [1:0] g_cfg_lbc;

    p12_cfg_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .configured(configured),
        .run_lb(run_lb), .run_lbc(run_lbc), .g_se(g_se), .g_sc(g_sc),
        .g_cfg_lbc(g_cfg_lbc), .g_lb(g_lb), .g_ff_gate(g_ff_gate),
        .g_l_gate(g_l_gate), .g_sc_ret(g_sc_ret)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] chain;
    logic [N-1:0] preload_val = '0;
    logic         preload_req = 1'b0;
    logic [N-1:0] exp_chain;
    logic [7:0]   rd_q[$];
    logic [7:0]   mon_exp;
    logic [7:0]   load_bytes[4*NB];
    int fall_cycle, ff_cnt, gate_viol;
    int code_cnt[4];

    // Oldest bit leaves the chain first; new bits enter at the top.
    assign g_sc_ret = chain[0];

    // Grid scan chain model.
    always @(posedge clk) begin
        if (preload_req) chain <= preload_val;
        else if (g_se && g_ff_gate) chain <= {g_sc, chain[N-1:1]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, configured, in_ready, rd_valid, rd_data,
                    g_se, g_sc, g_lb, g_ff_gate, g_l_gate, g_cfg_lbc});
    endfunction

    // Readback monitor: pops the scoreboard on every rd_valid strobe.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
            end else begin
                mon_exp = rd_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(mon_exp));
            end
        end
    end

    task automatic do_load(input int mode, input bit abort_h, input bit extra_start);
        int idx;
        int j;
        bit done;
        idx = 0; j = 0; done = 1'b0;
        ff_cnt = 0; gate_viol = 0; fall_cycle = -1;
        for (int c = 0; c < 4; c++) code_cnt[c] = 0;
        for (int i = 0; i < NB; i++) rd_q.push_back(exp_chain[8*i +: 8]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done) begin
            if (!busy) begin
                fall_cycle = j;
                done = 1'b1;
            end else if (abort_h && g_cfg_lbc == 2'd2) begin
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1 check("reset_async", outs(), 64'(run_lbc));
                check("rd_q_after_abort", 64'(rd_q.size()), 64'd0);
                for (int i = 0; i < NB; i++) exp_chain[8*i +: 8] = load_bytes[NB + i];
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                done = 1'b1;
            end else begin
                if (g_ff_gate) ff_cnt++;
                if (g_cfg_lbc != 2'd0) begin
                    code_cnt[g_cfg_lbc]++;
                    if (g_ff_gate || !g_se) gate_viol++;
                end
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = ((j / 5) % 2) == 0;
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                in_data = (idx < 4*NB) ? load_bytes[idx] : 8'($urandom);
                if (in_valid && in_ready) idx++;
                start = extra_start && (j == 100);
                j++;
                if (j > 4000) begin
                    checks++;
                    errors++;
                    $display("FAIL load_timeout actual=busy required=idle");
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic post_checks(input bit timing);
        logic [N-1:0] fin;
        for (int i = 0; i < NB; i++) fin[8*i +: 8] = load_bytes[3*NB + i];
        check("chain_final", 64'(chain), 64'(fin));
        check("ff_gate_cycles", 64'(ff_cnt), 64'(4*N));
        check("code_v_cycles", 64'(code_cnt[1]), 64'd2);
        check("code_h_cycles", 64'(code_cnt[2]), 64'd2);
        check("code_d_cycles", 64'(code_cnt[3]), 64'd2);
        check("strobe_gate", 64'(gate_viol), 64'd0);
        check("rd_count", 64'(rd_q.size()), 64'd0);
        check("configured", 64'(configured), 64'd1);
        if (timing) check("busy_fall", 64'(fall_cycle), 64'd263);
        else        check("busy_fall_seen", 64'(fall_cycle > 0), 64'd1);
        exp_chain = fin;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        run_lbc = 2'($urandom_range(0, 3));
        #2 rst_n = 1'b0;
        #1 check("reset_async_start", outs(), 64'(run_lbc));
        @(negedge clk); @(negedge clk);
        check("reset_held", outs(), 64'(run_lbc));
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outs() !== 64'(run_lbc)) bad++;
        end
        check("idle_static", 64'(bad), 64'd0);

        for (int i = 0; i < 4*NB; i++) load_bytes[i] = 8'(i);
        preload_val = {NB{8'hA5}};
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        exp_chain = preload_val;
        do_load(0, 1'b0, 1'b1);
        post_checks(1'b1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("start_ignored_busy", 64'(bad), 64'd0);

        run_lb = 1'b1; run_lbc = 2'd2;
        @(negedge clk); @(negedge clk);
        check("run_mode", 64'({g_lb, g_cfg_lbc, g_se, g_ff_gate, g_l_gate, in_ready}),
              64'({1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            run_lb = 1'($urandom_range(0, 1));
            run_lbc = 2'($urandom_range(0, 3));
            @(negedge clk); @(negedge clk);
            check("run_mode_rand", 64'({g_lb, g_cfg_lbc, g_se, g_ff_gate, g_l_gate}),
                  64'({run_lb, run_lbc, 1'b0, 1'b1, 1'b1}));
        end
        run_lb = 1'b0; run_lbc = 2'd0;

        do_load(1, 1'b0, 1'b0);
        post_checks(1'b0);

        for (int i = 0; i < 4*NB; i++) load_bytes[i] = 8'($urandom);
        do_load(2, 1'b0, 1'b0);
        post_checks(1'b0);

        for (int i = 0; i < 4*NB; i++) load_bytes[i] = 8'($urandom);
        do_load(0, 1'b1, 1'b0);
        @(negedge clk);
        check("after_abort_idle", outs(), 64'(run_lbc));

        for (int i = 0; i < 4*NB; i++) load_bytes[i] = 8'($urandom);
        do_load(2, 1'b0, 1'b0);
        post_checks(1'b0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
